zap_regf_wb_queue: RTL

Write-back queue that sits directly upstream of the 64x32 register-file RAM, which has two write ports sharing one enable and four combinational read ports. It accepts up to two write-back results per cycle from the pipeline, buffers them in order, and drains them onto the RAM write ports. It also forwards queued, not-yet-committed data onto the four read ports, so readers always see the youngest value.

---
 rtl/zap_regf_wb_queue_pkg.sv | 13 +
 rtl/zap_regf_wb_queue_if.sv | 38 +++
 rtl/zap_regf_wb_queue_fwd_mux.sv | 27 ++
 rtl/zap_regf_wb_queue.sv | 136 +++++++++++++
 4 files changed

// File: rtl/zap_regf_wb_queue_pkg.sv
// Shared register-file geometry and the write-back queue entry record.
package zap_regf_wb_queue_pkg;

    localparam int ZAP_RF_AW     = 6;
    localparam int ZAP_RF_DW     = 32;
    localparam int ZAP_WBQ_DEPTH = 4;

    typedef struct packed {
        logic [ZAP_RF_AW-1:0] addr;
        logic [ZAP_RF_DW-1:0] data;
    } zap_wbq_entry_t;

endpackage

// File: rtl/zap_regf_wb_queue_if.sv
// Pipeline write-back, RAM write and forwarded read signals of the write-back queue.
interface zap_regf_wb_queue_if
    import zap_regf_wb_queue_pkg::*;
#(
    parameter int AW    = ZAP_RF_AW,
    parameter int DW    = ZAP_RF_DW,
    parameter int DEPTH = ZAP_WBQ_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_valid_a, i_valid_b, i_hold;
    logic [AW-1:0] i_addr_a, i_addr_b;
    logic [DW-1:0] i_data_a, i_data_b;
    logic          o_ready, o_wen;
    logic [AW-1:0] o_wr_addr_a, o_wr_addr_b;
    logic [DW-1:0] o_wr_data_a, o_wr_data_b;
    logic [AW-1:0] i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d;
    logic [DW-1:0] i_ram_data_a, i_ram_data_b, i_ram_data_c, i_ram_data_d;
    logic [DW-1:0] o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d;
    logic [CW-1:0] o_count;

    modport master (
        output i_valid_a, i_valid_b, i_hold, i_addr_a, i_addr_b, i_data_a, i_data_b,
        output i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d,
        output i_ram_data_a, i_ram_data_b, i_ram_data_c, i_ram_data_d,
        input  o_ready, o_wen, o_wr_addr_a, o_wr_addr_b, o_wr_data_a, o_wr_data_b,
        input  o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d, o_count
    );

    modport slave (
        input  i_valid_a, i_valid_b, i_hold, i_addr_a, i_addr_b, i_data_a, i_data_b,
        input  i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d,
        input  i_ram_data_a, i_ram_data_b, i_ram_data_c, i_ram_data_d,
        output o_ready, o_wen, o_wr_addr_a, o_wr_addr_b, o_wr_data_a, o_wr_data_b,
        output o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d, o_count
    );

endinterface

// File: rtl/zap_regf_wb_queue_fwd_mux.sv
// Priority address match over age-ordered queue entries; index 0 is the youngest.
module zap_regf_fwd_mux #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic [DEPTH-1:0]         vld_i,
    input  logic [DEPTH-1:0][AW-1:0] addr_i,
    input  logic [DEPTH-1:0][DW-1:0] data_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic                     hit_o,
    output logic [DW-1:0]            data_o
);

    // Walk oldest to youngest so the youngest match is the last one assigned.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (vld_i[k] && (addr_i[k] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[k];
            end
        end
    end

endmodule

// File: rtl/zap_regf_wb_queue.sv
// In-order write-back queue in front of the dual-write register-file RAM, with
// youngest-value forwarding of uncommitted entries onto the four read ports.
module zap_regf_wb_queue
    import zap_regf_wb_queue_pkg::*;
#(
    parameter int DEPTH = ZAP_WBQ_DEPTH,
    parameter int AW    = ZAP_RF_AW,
    parameter int DW    = ZAP_RF_DW
) (
    input  logic                i_clk,
    input  logic                i_reset,
    zap_regf_wb_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    zap_wbq_entry_t mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, slot_b;
    logic [CW-1:0]  count_q, count_d;
    logic           ready_q, ready_d;
    logic           push_a, push_b, wen;
    logic [1:0]     push_n, pop_n;
    zap_wbq_entry_t e0, e1, port_a, port_b;

    // Drain side: pop up to two from the head; a same-address pair collapses to the younger.
    always_comb begin
        e0     = mem_q[head_q];
        e1     = mem_q[head_q + PW'(1)];
        pop_n  = 2'd0;
        wen    = 1'b0;
        port_a = '0;
        port_b = '0;
        if (!i_reset && !bus.i_hold && (count_q != '0)) begin
            wen = 1'b1;
            if (count_q == CW'(1)) begin
                pop_n  = 2'd1;
                port_a = e0;
                port_b = e0;
            end else begin
                pop_n  = 2'd2;
                port_a = (e0.addr == e1.addr) ? e1 : e0;
                port_b = e1;
            end
        end
    end

    // Fill side: B overrides A when both target the same register.
    always_comb begin
        push_a  = ready_q && bus.i_valid_a && !(bus.i_valid_b && (bus.i_addr_a == bus.i_addr_b));
        push_b  = ready_q && bus.i_valid_b;
        push_n  = {1'b0, push_a} + {1'b0, push_b};
        slot_b  = push_a ? tail_q + PW'(1) : tail_q;
        tail_d  = tail_q + PW'(push_n);
        head_d  = head_q + PW'(pop_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        ready_d = (count_d <= CW'(DEPTH - 2));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_a) mem_q[tail_q] <= '{addr: bus.i_addr_a, data: bus.i_data_a};
        if (push_b) mem_q[slot_b] <= '{addr: bus.i_addr_b, data: bus.i_data_b};
    end

    assign bus.o_wen       = wen;
    assign bus.o_wr_addr_a = port_a.addr;
    assign bus.o_wr_addr_b = port_b.addr;
    assign bus.o_wr_data_a = port_a.data;
    assign bus.o_wr_data_b = port_b.data;
    assign bus.o_ready     = ready_q;
    assign bus.o_count     = count_q;

    // Age-ordered view for forwarding; entries being popped still count as valid.
    logic [DEPTH-1:0]         fwd_vld;
    logic [DEPTH-1:0][AW-1:0] fwd_addr;
    logic [DEPTH-1:0][DW-1:0] fwd_data;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            fwd_vld[k]  = (CW'(k) < count_q);
            fwd_addr[k] = mem_q[tail_q - PW'(k + 1)].addr;
            fwd_data[k] = mem_q[tail_q - PW'(k + 1)].data;
        end
    end

    logic [AW-1:0] rd_addr [4];
    logic [DW-1:0] ram_data [4];
    logic [DW-1:0] hit_data [4];
    logic [DW-1:0] rd_out [4];
    logic          hit [4];

    assign rd_addr[0]  = bus.i_rd_addr_a;
    assign rd_addr[1]  = bus.i_rd_addr_b;
    assign rd_addr[2]  = bus.i_rd_addr_c;
    assign rd_addr[3]  = bus.i_rd_addr_d;
    assign ram_data[0] = bus.i_ram_data_a;
    assign ram_data[1] = bus.i_ram_data_b;
    assign ram_data[2] = bus.i_ram_data_c;
    assign ram_data[3] = bus.i_ram_data_d;

    for (genvar p = 0; p < 4; p++) begin : g_fwd
        zap_regf_fwd_mux #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
            .vld_i     (fwd_vld),
            .addr_i    (fwd_addr),
            .data_i    (fwd_data),
            .rd_addr_i (rd_addr[p]),
            .hit_o     (hit[p]),
            .data_o    (hit_data[p])
        );
        assign rd_out[p] = hit[p] ? hit_data[p] : ram_data[p];
    end

    assign bus.o_rd_data_a = rd_out[0];
    assign bus.o_rd_data_b = rd_out[1];
    assign bus.o_rd_data_c = rd_out[2];
    assign bus.o_rd_data_d = rd_out[3];

`ifdef SIM
    a_count_bound: assert property (@(posedge i_clk) count_q <= CW'(DEPTH));
`endif

endmodule
